// File: rtl/display_pkg.sv
// Shared types and constants for the score display engine.
// Modes, FSM states, segment constants and the BCD add-3 helper.
package display_pkg;

  typedef enum logic [1:0] {
    MODE_DEC   = 2'd0,
    MODE_SPLIT = 2'd1,
    MODE_HEX   = 2'd2,
    MODE_OFF   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SPLIT_LOAD,
    ST_COMMIT
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/score_display_mux_if.sv
// Value-select / display bus of the score display engine.
// master: drives values, select, mode, blank_en, update; slave: drives segments, busy, overflow.
interface score_display_mux_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int VALUE_WIDTH  = 20,
  parameter int NUM_DIGITS   = 6,
  parameter int SEL_WIDTH    = 2
);

  logic [NUM_CHANNELS*VALUE_WIDTH-1:0] channel_values;
  logic [SEL_WIDTH-1:0]                channel_sel;
  logic [1:0]                          mode;
  logic                                blank_en;
  logic                                update;
  logic [NUM_DIGITS*7-1:0]             segments;
  logic                                busy;
  logic                                overflow;

  modport master (
    output channel_values,
    output channel_sel,
    output mode,
    output blank_en,
    output update,
    input  segments,
    input  busy,
    input  overflow
  );

  modport slave (
    input  channel_values,
    input  channel_sel,
    input  mode,
    input  blank_en,
    input  update,
    output segments,
    output busy,
    output overflow
  );

endinterface

// File: rtl/seg7_encode.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Ports: nibble (4-bit in), seg (7-bit out).
module seg7_encode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/score_display_mux.sv
// Serial value-to-7-segment display engine (double-dabble BCD, split, hex, off).
// Ports: clock, reset_n (async low), bus (slave: values/sel/mode/blank_en/update in; segments/busy/overflow out).
module score_display_mux #(
  parameter int NUM_CHANNELS = 4,
  parameter int VALUE_WIDTH  = 20,
  parameter int NUM_DIGITS   = 6,
  parameter int SEL_WIDTH    = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  score_display_mux_if.slave  bus
);

  import display_pkg::*;

  localparam int W  = VALUE_WIDTH;
  localparam int HW = W / 2;
  localparam int D  = NUM_DIGITS;
  localparam int HD = D / 2;
  localparam int BW = 4 * D;
  localparam int CW = $clog2(W + 1);

  state_t          state_q, state_d;
  logic [W-1:0]    sel_val;
  logic [W-1:0]    sh_val;
  mode_t           sh_mode;
  logic            sh_blank;
  logic            pend;
  logic [W-1:0]    sr;
  logic [BW-1:0]   bcd;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_next;
  logic [4*HD-1:0] lo_bcd;
  logic            ovf_run;
  logic            ovf_lo;
  logic            phase_hi;
  logic            shift_out;
  logic [CW-1:0]   cnt;
  logic            sample;
  logic [D*7-1:0]  seg_q;
  logic            ovf_q;
  logic [BW-1:0]   nib;
  logic [D*7-1:0]  enc;
  logic [D*7-1:0]  seg_next;
  logic [D-1:0]    blank_d;
  logic [D-1:0]    dash_d;
  logic            ovf_next;
  logic            lead;

  // Out-of-range selects read as zero.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (bus.channel_sel == SEL_WIDTH'(k)) begin
        sel_val = bus.channel_values[k*W +: W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (bus.update) state_d = ST_LOAD;
      ST_LOAD:
        if (sh_mode == MODE_HEX || sh_mode == MODE_OFF)
          state_d = ST_COMMIT;
        else
          state_d = ST_SHIFT;
      ST_SHIFT:
        if (cnt == CW'(1)) begin
          if (sh_mode == MODE_SPLIT && !phase_hi)
            state_d = ST_SPLIT_LOAD;
          else
            state_d = ST_COMMIT;
        end
      ST_SPLIT_LOAD:
        state_d = ST_SHIFT;
      ST_COMMIT:
        if (pend || bus.update) state_d = ST_LOAD;
        else                    state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  assign sample = (state_q == ST_IDLE && bus.update) ||
                  (state_q == ST_COMMIT && (pend || bus.update));

  // One double-dabble step; in split mode only the low field is live,
  // so the bit leaving that field is the overflow and is masked off.
  always_comb begin
    for (int i = 0; i < D; i++) begin
      bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
    end
    bcd_next = {bcd_adj[BW-2:0], sr[W-1]};
    shift_out = bcd_adj[BW-1];
    if (sh_mode == MODE_SPLIT) begin
      shift_out = bcd_adj[4*HD-1];
      bcd_next[BW-1:4*HD] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_val   <= '0;
      sh_mode  <= MODE_DEC;
      sh_blank <= 1'b0;
      pend     <= 1'b0;
      sr       <= '0;
      bcd      <= '0;
      lo_bcd   <= '0;
      ovf_run  <= 1'b0;
      ovf_lo   <= 1'b0;
      phase_hi <= 1'b0;
      cnt      <= '0;
      seg_q    <= {D{SEG_BLANK}};
      ovf_q    <= 1'b0;
    end else begin
      if (sample) begin
        sh_val   <= sel_val;
        sh_mode  <= mode_t'(bus.mode);
        sh_blank <= bus.blank_en;
      end
      if (state_q == ST_COMMIT)
        pend <= 1'b0;
      else if (state_q != ST_IDLE && bus.update)
        pend <= 1'b1;
      unique case (state_q)
        ST_LOAD: begin
          bcd      <= '0;
          ovf_run  <= 1'b0;
          phase_hi <= 1'b0;
          if (sh_mode == MODE_SPLIT) begin
            sr  <= {sh_val[HW-1:0], {(W-HW){1'b0}}};
            cnt <= CW'(HW);
          end else begin
            sr  <= sh_val;
            cnt <= CW'(W);
          end
        end
        ST_SHIFT: begin
          bcd     <= bcd_next;
          sr      <= sr << 1;
          ovf_run <= ovf_run | shift_out;
          cnt     <= cnt - CW'(1);
        end
        ST_SPLIT_LOAD: begin
          lo_bcd   <= bcd[4*HD-1:0];
          ovf_lo   <= ovf_run;
          bcd      <= '0;
          ovf_run  <= 1'b0;
          phase_hi <= 1'b1;
          sr       <= {sh_val[W-1:HW], {(W-HW){1'b0}}};
          cnt      <= CW'(HW);
        end
        ST_COMMIT: begin
          seg_q <= seg_next;
          ovf_q <= ovf_next;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < D; g++) begin : g_enc
    seg7_encode u_enc (
      .nibble (nib[4*g +: 4]),
      .seg    (enc[7*g +: 7])
    );
  end

  // Digit contents at commit: dashes beat blanking beat the encoder.
  always_comb begin
    nib      = bcd;
    ovf_next = 1'b0;
    dash_d   = '0;
    blank_d  = '0;
    lead     = 1'b1;
    seg_next = '0;
    unique case (sh_mode)
      MODE_DEC: begin
        ovf_next = ovf_run;
        dash_d   = {D{ovf_run}};
      end
      MODE_SPLIT: begin
        nib      = {bcd[4*HD-1:0], lo_bcd};
        ovf_next = ovf_run | ovf_lo;
        dash_d   = {{(D-HD){ovf_run}}, {HD{ovf_lo}}};
      end
      MODE_HEX: nib = BW'(sh_val);
      MODE_OFF: blank_d = '1;
    endcase
    if (sh_blank && (sh_mode == MODE_DEC || sh_mode == MODE_SPLIT)) begin
      for (int d = D - 1; d >= 0; d--) begin
        if (sh_mode == MODE_SPLIT && d == HD - 1) lead = 1'b1;
        if (nib[4*d +: 4] != 4'd0) lead = 1'b0;
        if (d != 0 && !(sh_mode == MODE_SPLIT && d == HD))
          blank_d[d] = lead;
      end
    end
    for (int d = 0; d < D; d++) begin
      if (dash_d[d])       seg_next[7*d +: 7] = SEG_DASH;
      else if (blank_d[d]) seg_next[7*d +: 7] = SEG_BLANK;
      else                 seg_next[7*d +: 7] = enc[7*d +: 7];
    end
  end

  assign bus.segments = seg_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_score_display_mux.sv
// Scoreboard bench for score_display_mux (W=20, D=6, 4 channels).
// Stimulus queues expected commits; a negedge monitor pops and compares them.
module tb_score_display_mux;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  typedef struct {
    string       name;
    logic [41:0] seg;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];

  score_display_mux_if #(
    .NUM_CHANNELS (4),
    .VALUE_WIDTH  (20),
    .NUM_DIGITS   (6),
    .SEL_WIDTH    (2)
  ) bus ();

  score_display_mux #(
    .NUM_CHANNELS (4),
    .VALUE_WIDTH  (20),
    .NUM_DIGITS   (6),
    .SEL_WIDTH    (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [41:0] rep(input logic [6:0] s);
    return {6{s}};
  endfunction

  // Monitor: a commit shows as a change of the display or busy falling.
  logic [41:0] prev_seg = '1;
  logic        prev_ovf = 1'b0;
  logic        prev_busy = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_seg  <= bus.segments;
      prev_ovf  <= bus.overflow;
      prev_busy <= 1'b0;
    end else begin
      if (bus.segments !== prev_seg || bus.overflow !== prev_ovf ||
          (prev_busy && !bus.busy)) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", 64'(bus.segments), 64'(prev_seg));
        end else begin
          chk({sb[0].name, "_seg"}, 64'(bus.segments), 64'(sb[0].seg));
          chk({sb[0].name, "_ovf"}, 64'(bus.overflow), 64'(sb[0].ovf));
          chk({sb[0].name, "_lat"}, 64'(cyc), 64'(sb[0].due));
          sb.delete(0);
        end
      end
      prev_seg  <= bus.segments;
      prev_ovf  <= bus.overflow;
      prev_busy <= bus.busy;
    end
  end

  task automatic issue(input string name, input int ch,
                       input logic [19:0] val, input logic [1:0] sel,
                       input logic [1:0] md, input logic bl,
                       input logic [41:0] eseg, input logic eovf,
                       input int lat);
    int bcnt;
    bit done;
    @(negedge clock);
    bus.channel_values[ch*20 +: 20] = val;
    bus.channel_sel = sel;
    bus.mode = md;
    bus.blank_en = bl;
    bus.update = 1'b1;
    sb.push_back('{name: name, seg: eseg, ovf: eovf, due: cyc + 1 + lat});
    @(negedge clock);
    bus.update = 1'b0;
    bus.channel_values = 80'({$urandom, $urandom, $urandom});
    bus.channel_sel = 2'($urandom);
    bus.mode = 2'($urandom);
    bus.blank_en = 1'($urandom);
    bcnt = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.busy) bcnt++;
      if (!bus.busy && sb.size() == 0) done = 1'b1;
      else @(negedge clock);
    end
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_busy"}, 64'(bcnt), 64'(lat));
  endtask

  initial begin
    int c0;
    bit hit;
    bus.channel_values = '0;
    bus.channel_sel = '0;
    bus.mode = 2'd0;
    bus.blank_en = 1'b0;
    bus.update = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_seg", 64'(bus.segments), 64'(rep(7'h7F)));
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;

    issue("dec_123456", 0, 20'd123456, 2'd0, 2'd0, 1'b1,
          {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 1'b0, 22);
    issue("dec_zero_bl", 1, 20'd0, 2'd1, 2'd0, 1'b1,
          {{5{7'h7F}}, 7'h40}, 1'b0, 22);
    issue("dec_zero_nobl", 1, 20'd0, 2'd1, 2'd0, 1'b0,
          rep(7'h40), 1'b0, 22);
    issue("split_7_10", 2, 20'h01C0A, 2'd2, 2'd1, 1'b1,
          {7'h7F, 7'h7F, 7'h78, 7'h7F, 7'h79, 7'h40}, 1'b0, 23);
    issue("dec_fffff", 3, 20'hFFFFF, 2'd3, 2'd0, 1'b1,
          rep(7'h3F), 1'b1, 22);
    issue("dec_5", 3, 20'd5, 2'd3, 2'd0, 1'b1,
          {{5{7'h7F}}, 7'h12}, 1'b0, 22);
    issue("hex_abcde", 0, 20'hABCDE, 2'd0, 2'd2, 1'b1,
          {7'h40, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06}, 1'b0, 2);
    issue("off", 0, 20'd1, 2'd0, 2'd3, 1'b0,
          rep(7'h7F), 1'b0, 2);
    issue("split_ovf_lo", 2, 20'd6120, 2'd2, 2'd1, 1'b1,
          {7'h7F, 7'h7F, 7'h12, 7'h3F, 7'h3F, 7'h3F}, 1'b1, 23);
    issue("dec_999999", 1, 20'd999999, 2'd1, 2'd0, 1'b0,
          rep(7'h10), 1'b0, 22);
    issue("dec_1000000", 1, 20'd1000000, 2'd1, 2'd0, 1'b0,
          rep(7'h3F), 1'b1, 22);

    // Reset in the middle of a shift sequence.
    @(negedge clock);
    bus.channel_values[19:0] = 20'd7;
    bus.channel_sel = 2'd0;
    bus.mode = 2'd0;
    bus.blank_en = 1'b1;
    bus.update = 1'b1;
    @(negedge clock);
    bus.update = 1'b0;
    repeat (8) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_seg", 64'(bus.segments), 64'(rep(7'h7F)));
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_ovf", 64'(bus.overflow), 64'd0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("midrst_nocommit_seg", 64'(bus.segments), 64'(rep(7'h7F)));
    chk("midrst_nocommit_busy", 64'(bus.busy), 64'd0);

    // Back-to-back: second request lands while busy, extra pulse merges.
    @(negedge clock);
    bus.channel_values[19:0] = 20'd123456;
    bus.channel_values[39:20] = 20'd42;
    bus.channel_sel = 2'd0;
    bus.mode = 2'd0;
    bus.blank_en = 1'b1;
    bus.update = 1'b1;
    c0 = cyc;
    sb.push_back('{name: "b2b_first",
                   seg: {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02},
                   ovf: 1'b0, due: c0 + 1 + 22});
    @(negedge clock);
    bus.update = 1'b0;
    repeat (4) @(negedge clock);
    bus.channel_sel = 2'd1;
    bus.update = 1'b1;
    sb.push_back('{name: "b2b_second",
                   seg: {{4{7'h7F}}, 7'h19, 7'h24},
                   ovf: 1'b0, due: c0 + 1 + 44});
    @(negedge clock);
    bus.update = 1'b0;
    @(negedge clock);
    bus.update = 1'b1;
    @(negedge clock);
    bus.update = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (cyc == c0 + 1 + 22) hit = 1'b1;
      else @(negedge clock);
    end
    chk("b2b_reach_commit", 64'(hit), 64'd1);
    chk("b2b_busy_held", 64'(bus.busy), 64'd1);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (!bus.busy && sb.size() == 0) hit = 1'b1;
      else @(negedge clock);
    end
    chk("b2b_done", 64'(hit), 64'd1);
    repeat (30) @(negedge clock);
    chk("b2b_merged_idle", 64'(bus.busy), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
